// File: rtl/cdc_toggle_rx_pkg.sv
// Shared definitions for the toggle req/ack receive endpoint: buffer occupancy
// encodings and the default synchronizer depth.
package cdc_toggle_rx_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } occ_e;

    // A capture may only be granted from the registered occupancy, never from
    // the same-cycle pop, so that m_ready has no path to the ack.
    function automatic logic has_space(input logic [1:0] count);
        return count != CNT_FULL;
    endfunction

endpackage

// File: rtl/cdc_toggle_rx_fifo2_reg.sv
// Two-entry register FIFO. Entry 0 is always the head, so the read data is a
// plain flop output and stays stable while the consumer stalls.
module fifo2_reg
    import cdc_toggle_rx_pkg::*;
#(
    parameter int NUM_BITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [NUM_BITS-1:0] push_data,
    input  logic                pop,
    output logic [1:0]          count,
    output logic [NUM_BITS-1:0] head
);

    occ_e                count_q, count_d;
    logic [NUM_BITS-1:0] entry0_q, entry0_d;
    logic [NUM_BITS-1:0] entry1_q, entry1_d;
    logic                push_ok;
    logic                pop_ok;

    assign push_ok = push && (count_q != CNT_FULL);
    assign pop_ok  = pop && (count_q != CNT_EMPTY);

    // NOTE: every always_comb output gets its hold value first, so no path
    // through the case can leave a variable unassigned and infer a latch.
    always_comb begin
        count_d  = count_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        case (count_q)
            CNT_EMPTY: begin
                if (push_ok) begin
                    entry0_d = push_data;
                    count_d  = CNT_ONE;
                end
            end
            CNT_ONE: begin
                if (push_ok && pop_ok) begin
                    entry0_d = push_data;
                end else if (push_ok) begin
                    entry1_d = push_data;
                    count_d  = CNT_FULL;
                end else if (pop_ok) begin
                    count_d = CNT_EMPTY;
                end
            end
            CNT_FULL: begin
                if (pop_ok) begin
                    entry0_d = entry1_q;
                    count_d  = CNT_ONE;
                end
            end
            default: count_d = CNT_EMPTY;
        endcase
    end

    // NOTE: the storage is reset as well because the head is visible on the
    // output port and must read 0 out of reset; a deeper memory would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= CNT_EMPTY;
            entry0_q <= '0;
            entry1_q <= '0;
        end else begin
            count_q  <= count_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
        end
    end

    assign count = count_q;
    assign head  = entry0_q;

endmodule

// File: rtl/cdc_toggle_rx.sv
// Destination endpoint of the toggle req/ack crossing: synchronizes the request
// toggle, captures the frozen sender word into a 2-entry buffer and returns ack.
module cdc_toggle_rx
    import cdc_toggle_rx_pkg::*;
#(
    parameter int NUM_BITS    = 1,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int CNT_BITS    = 16
) (
    input  logic                clk_out,
    input  logic                resetn,
    input  logic                req_toggle,
    input  logic [NUM_BITS-1:0] bits_in,
    output logic                ack_toggle,
    output logic                m_valid,
    output logic [NUM_BITS-1:0] m_data,
    input  logic                m_ready,
    output logic                pending,
    output logic [CNT_BITS-1:0] xfer_count
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   ack_q, ack_d;
    logic [CNT_BITS-1:0]    xfer_count_q, xfer_count_d;
    logic                   req_sync;
    logic                   capture;
    logic                   pop;
    logic [1:0]             fifo_count;

    // bits_in is held stable by the sender for the whole handshake, so its
    // path into the buffer is timed as a false path.
    (* false_path = "true" *) logic [NUM_BITS-1:0] capture_data;
    assign capture_data = bits_in;

    assign req_sync = sync_q[SYNC_STAGES-1];
    assign pending  = req_sync ^ ack_q;
    assign capture  = pending && has_space(fifo_count);
    assign m_valid  = (fifo_count != CNT_EMPTY);
    assign pop      = m_valid && m_ready;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], req_toggle};
        ack_d        = ack_q ^ capture;
        xfer_count_d = xfer_count_q;
        if (capture) begin
            xfer_count_d = xfer_count_q + 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk_out or negedge resetn) begin
        if (!resetn) begin
            sync_q       <= '0;
            ack_q        <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            sync_q       <= sync_d;
            ack_q        <= ack_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    fifo2_reg #(
        .NUM_BITS (NUM_BITS)
    ) u_fifo (
        .clk       (clk_out),
        .rst_n     (resetn),
        .push      (capture),
        .push_data (capture_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (m_data)
    );

    assign ack_toggle = ack_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: doc/cdc_toggle_rx.md
# cdc_toggle_rx

Destination-side endpoint of the closed-loop toggle req/ack data crossing. It lives entirely in the output clock domain and synchronizes the sender's request toggle. It captures the sender's frozen data word into a 2-entry buffer and returns the acknowledge toggle. Unlike a bare output register, it presents the data on a valid/ready stream, so downstream backpressure throttles the sender through delayed acks.

## Interface
- NUM_BITS, 1, width of the transferred data word
- SYNC_STAGES, 2, flops in the request synchronizer (minimum 2)
- CNT_BITS, 16, width of the transfer counter
- clk_out  input  1  destination-domain clock
- resetn  input  1  reset: one clock; reset is asynchronous and active-low
- req_toggle  input  1  request toggle from the sender domain (asynchronous)
- bits_in  input  NUM_BITS  sender's frozen data word; held stable while req_toggle != ack_toggle; false path
- ack_toggle  output  1  acknowledge toggle back to the sender domain; registered
- m_valid  output  1  buffer head valid
- m_data  output  NUM_BITS  buffer head data
- m_ready  input  1  downstream accept
- pending  output  1  request seen (synchronized req != ack) but not yet captured
- xfer_count  output  CNT_BITS  captures since reset, wraps modulo 2^CNT_BITS

## Operation
- Synchronizer: SYNC_STAGES-flop chain on req_toggle, giving req_sync.
- A request is pending when req_sync != ack_toggle.
- Capture condition: pending AND buffer occupancy (registered count) < 2. On a capture edge:
  - bits_in is written to the tail.
  - ack_toggle inverts.
  - xfer_count increments.
- Buffer: 2-entry FIFO with count in {0,1,2}. A pop occurs when m_valid && m_ready.
  - m_data always shows the head entry.
  - m_valid = (count != 0).
- States, as a function of count:
  - EMPTY: count 0.
  - ONE: count 1.
  - FULL: count 2.
- Transitions:
  - Capture only: count + 1.
  - Pop only: count − 1.
  - Capture and pop together: count unchanged (allowed in ONE only).
- FULL plus pending: no capture and ack is withheld, so the sender stays stalled. A pop in FULL does not enable a capture in the same cycle; the capture happens on the next edge. There is no combinational path from m_ready to ack_toggle.
- No overrun is possible: the sender cannot issue a new request until the ack toggles.
- Reset values:
  - Synchronizer flops 0.
  - ack_toggle 0, count 0, m_valid 0, m_data 0, xfer_count 0, pending 0.
- Reset asserted mid-operation: buffer contents are discarded.
  - If req_toggle is 1 after release, the mismatch is treated as a new request and captured after synchronization.
  - The sender domain must be reset together with this block.

## Timing
- req_toggle is first sampled at edge E0. req_sync updates at edge E0+SYNC_STAGES−1. The capture happens at E0+SYNC_STAGES when there is buffer space.
- m_valid and ack_toggle both change on the capture edge. Latency from req sample to m_valid is SYNC_STAGES+1 edges (3 with default).
- Pop: the head advances on the edge where m_valid && m_ready. The second entry is visible on m_data in the following cycle.
- Sustained throughput is bounded by the round trip, not by this block. With m_ready held high, the block never delays an ack beyond the capture edge.
- m_data and m_valid are stable while m_valid && !m_ready.
- xfer_count wraps from 2^CNT_BITS−1 to 0 with no flag.

## Structure
- Shared package: occupancy encodings CNT_EMPTY=0, CNT_ONE=1, CNT_FULL=2, and the default SYNC_STAGES constant.
- Sub-module fifo2_reg: 2-entry register FIFO with push, pop, count and head. Parameterized on NUM_BITS; async active-low reset.
- Top level holds:
  - the synchronizer chain, with ASYNC_REG attributes;
  - the ack register;
  - the capture logic;
  - the counter.
- bits_in carries the team false-path attribute on its capture path.

## Test plan
- Single transfer: req_toggle 0→1 with bits_in=0xA5 and m_ready=1.
  - Required: m_valid high for exactly one cycle at latency 3 with m_data=0xA5.
  - ack_toggle goes to 1 on the same edge; xfer_count=1.
- Backpressure: m_ready=0 and three requests with data 0x11, 0x22, 0x33.
  - Required: the first two are captured, the third stays pending with ack withheld.
  - Raise m_ready: data pops as 0x11, 0x22, 0x33 in order, and the third capture occurs one edge after the first pop.
- Simultaneous push/pop: count 1 with m_ready=1 while a request arrives.
  - Required: count stays 1, the head advances, and there is no bubble on m_valid.
- Reset mid-operation: count=2 when resetn is pulsed low.
  - Required: m_valid=0, ack_toggle=0 and xfer_count=0 immediately (async).
  - With req_toggle held at 1, a recapture of bits_in occurs SYNC_STAGES+1 edges after release.
- Counter wrap (CNT_BITS=4): 17 transfers.
  - Required: xfer_count reads 1 and data order is preserved.
- Randomized sender model with arbitrary clock ratio and random m_ready.
  - Required: every word is delivered exactly once, in order, with no duplicates.
